// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer slide-pot scanner: pot slots, channel map, reset gain.
package eq_pkg;

  localparam int          NUM_POTS  = 6;
  localparam logic [11:0] POT_RESET = 12'h800;

  typedef enum logic [2:0] {
    SLOT_LP  = 3'd0,
    SLOT_B1  = 3'd1,
    SLOT_B2  = 3'd2,
    SLOT_B3  = 3'd3,
    SLOT_HP  = 3'd4,
    SLOT_VOL = 3'd5
  } slot_e;

  // ADC channel wired to each pot, indexed by slot
  localparam logic [2:0] SLOT_CHNNL [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_e;

endpackage

// File: rtl/pot_regfile.sv
// Six 12-bit gain registers written one at a time by slot index.
// Build option POT_SMOOTH_EN: each write becomes a first-order IIR step toward the new reading.
module pot_regfile
  import eq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [2:0]                 widx,
  input  logic [11:0]                wdata,
  output logic [NUM_POTS-1:0][11:0]  pots
);

  for (genvar gi = 0; gi < NUM_POTS; gi++) begin : g_pot
    logic        sel;
    logic [11:0] pot_q;
    logic [11:0] pot_d;

    assign sel       = we && (widx == 3'(gi));
    assign pots[gi]  = pot_q;

`ifdef POT_SMOOTH_EN
    logic               primed_q;
    logic signed [13:0] diff;
    logic signed [13:0] step;
    logic signed [13:0] sum;
    logic               smooth_unused;

    assign diff          = $signed({2'b00, wdata}) - $signed({2'b00, pot_q});
    assign step          = diff >>> 2;
    assign sum           = $signed({2'b00, pot_q}) + step;
    assign smooth_unused = ^sum[13:12];
    // The first reading after reset seeds the filter instead of crawling up from unity
    assign pot_d         = primed_q ? sum[11:0] : wdata;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pot_q    <= POT_RESET;
        primed_q <= 1'b0;
      end else if (sel) begin
        pot_q    <= pot_d;
        primed_q <= 1'b1;
      end
    end
`else
    assign pot_d = wdata;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pot_q <= POT_RESET;
      end else if (sel) begin
        pot_q <= pot_d;
      end
    end
`endif
  end

endmodule

// File: rtl/slide_pot_scheduler.sv
// Round-robin ADC scheduler for the six equalizer pots with watchdog and sweep tracking.
// Optional smoothing of each reading is enabled by defining POT_SMOOTH_EN.
module slide_pot_scheduler
  import eq_pkg::*;
#(
  parameter int GAP_CYC     = 64,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                strt_cnv,
  output logic [2:0]          chnnl,
  input  logic                cnv_cmplt,
  input  logic [11:0]         res,
  output logic [11:0]         POT_LP,
  output logic [11:0]         POT_B1,
  output logic [11:0]         POT_B2,
  output logic [11:0]         POT_B3,
  output logic [11:0]         POT_HP,
  output logic [11:0]         VOL_POT,
  output logic [NUM_POTS-1:0] pot_upd,
  output logic                sweep_done,
  output logic                all_valid,
  output logic                timeout_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC);
  localparam int              GP_W     = $clog2(GAP_CYC);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  // Completion cycle plus GAP_CYC-1 gap cycles puts the next start GAP_CYC cycles later
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(GAP_CYC - 2);

  state_e              state_q, state_d;
  slot_e               slot_q, slot_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [GP_W-1:0]     gap_q, gap_d;
  logic                dirty_q, dirty_d;
  logic [NUM_POTS-1:0] pot_upd_q, pot_upd_d;
  logic                sweep_done_q, sweep_done_d;
  logic                all_valid_q, all_valid_d;
  logic                timeout_err_q, timeout_err_d;
  logic                we;
  logic [NUM_POTS-1:0][11:0] pots;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    dirty_d       = dirty_q;
    pot_upd_d     = '0;
    sweep_done_d  = 1'b0;
    all_valid_d   = all_valid_q;
    timeout_err_d = timeout_err_q;
    we            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_START;
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // Completion is tested first so it beats a same-cycle watchdog expiry
        if (cnv_cmplt) begin
          we        = 1'b1;
          pot_upd_d = NUM_POTS'(1) << slot_q;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else if (wdog_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          dirty_d       = 1'b1;
          gap_d         = '0;
          state_d       = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          if (slot_q == SLOT_VOL) begin
            slot_d       = SLOT_LP;
            sweep_done_d = 1'b1;
            if (!dirty_q) all_valid_d = 1'b1;
            dirty_d      = 1'b0;
          end else begin
            slot_d = slot_e'(slot_q + 3'd1);
          end
          state_d = en ? ST_START : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      slot_q        <= SLOT_LP;
      wdog_q        <= '0;
      gap_q         <= '0;
      dirty_q       <= 1'b0;
      pot_upd_q     <= '0;
      sweep_done_q  <= 1'b0;
      all_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      wdog_q        <= wdog_d;
      gap_q         <= gap_d;
      dirty_q       <= dirty_d;
      pot_upd_q     <= pot_upd_d;
      sweep_done_q  <= sweep_done_d;
      all_valid_q   <= all_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  pot_regfile u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .widx  (slot_q),
    .wdata (res),
    .pots  (pots)
  );

  assign strt_cnv    = (state_q == ST_START);
  assign chnnl       = SLOT_CHNNL[slot_q];
  assign pot_upd     = pot_upd_q;
  assign sweep_done  = sweep_done_q;
  assign all_valid   = all_valid_q;
  assign timeout_err = timeout_err_q;

  assign POT_LP  = pots[0];
  assign POT_B1  = pots[1];
  assign POT_B2  = pots[2];
  assign POT_B3  = pots[3];
  assign POT_HP  = pots[4];
  assign VOL_POT = pots[5];

endmodule

// File: tb/tb_slide_pot_scheduler.sv
// Directed bench for slide_pot_scheduler: sweep order, gap timing, watchdog, en parking, reset.
module tb_slide_pot_scheduler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOL_POT;
  logic [5:0]  pot_upd;
  logic        sweep_done;
  logic        all_valid;
  logic        timeout_err;

  slide_pot_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .strt_cnv    (strt_cnv),
    .chnnl       (chnnl),
    .cnv_cmplt   (cnv_cmplt),
    .res         (res),
    .POT_LP      (POT_LP),
    .POT_B1      (POT_B1),
    .POT_B2      (POT_B2),
    .POT_B3      (POT_B3),
    .POT_HP      (POT_HP),
    .VOL_POT     (VOL_POT),
    .pot_upd     (pot_upd),
    .sweep_done  (sweep_done),
    .all_valid   (all_valid),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wide_cnt  = 0;
  int sweep_cnt = 0;
  logic strt_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strt_cnv && strt_prev) wide_cnt <= wide_cnt + 1;
    if (sweep_done) sweep_cnt <= sweep_cnt + 1;
    strt_prev <= strt_cnv;
  end

  typedef struct {
    int          sl;
    logic [2:0]  ch;
    logic [11:0] rsp;
    logic [11:0] pot;
  } vec_t;

  vec_t t1 [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pot_of(input int sl);
    case (sl)
      0:       return POT_LP;
      1:       return POT_B1;
      2:       return POT_B2;
      3:       return POT_B3;
      4:       return POT_HP;
      default: return VOL_POT;
    endcase
  endfunction

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (strt_cnv) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_start(input logic [2:0] exp_ch, input int budget,
                              output int s_cyc, output bit ok);
    wait_start(budget, ok);
    check("start_seen", 32'(ok), 32'd1);
    s_cyc = cyc;
    if (ok) check("chnnl", 32'(chnnl), 32'(exp_ch));
  endtask

  task automatic respond(input int sl, input logic [11:0] r, input int dly,
                         input logic [11:0] exp, input bit drop_en, output int c_cyc);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      if (drop_en && k == 0) en = 1'b0;
    end
    cnv_cmplt = 1'b1;
    res       = r;
    c_cyc     = cyc;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    $display("conv slot=%0d res=0x%03h pot=0x%03h pot_upd=%06b", sl, r, pot_of(sl), pot_upd);
    check("pot_upd", 32'(pot_upd), 32'(1) << sl);
    check("pot_val", 32'(pot_of(sl)), 32'(exp));
  endtask

  task automatic conv(input int sl, input logic [11:0] r, input int dly, input logic [11:0] exp);
    int s_cyc, c_cyc;
    bit ok;
    expect_start(t1[sl].ch, 3000, s_cyc, ok);
    if (ok) respond(sl, r, dly, exp, 1'b0, c_cyc);
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 6; i++) check("rst_pot", 32'(pot_of(i)), 32'h800);
    check("rst_strt",    32'(strt_cnv),    32'd0);
    check("rst_pot_upd", 32'(pot_upd),     32'd0);
    check("rst_sweep",   32'(sweep_done),  32'd0);
    check("rst_valid",   32'(all_valid),   32'd0);
    check("rst_tmo",     32'(timeout_err), 32'd0);
  endtask

  initial begin
    int   s_cyc, c_cyc, prev_c, s2;
    bit   ok;
    logic [11:0] exp_hp;

    t1[0] = '{0, 3'd1, 12'h100, 12'h100};
    t1[1] = '{1, 3'd0, 12'h101, 12'h101};
    t1[2] = '{2, 3'd4, 12'h102, 12'h102};
    t1[3] = '{3, 3'd2, 12'h103, 12'h103};
    t1[4] = '{4, 3'd3, 12'h104, 12'h104};
    t1[5] = '{5, 3'd7, 12'h105, 12'h105};

    rst_n = 1'b0; en = 1'b0; cnv_cmplt = 1'b0; res = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;

    // Full sweep: channel order, values, latency and gap timing
    prev_c = 0;
    for (int i = 0; i < 6; i++) begin
      expect_start(t1[i].ch, 3000, s_cyc, ok);
      if (i > 0) check("gap_cycles", 32'(s_cyc - prev_c), 32'd64);
      if (i == 5) check("valid_before_wrap", 32'(all_valid), 32'd0);
      if (ok) respond(i, t1[i].rsp, 100, t1[i].pot, 1'b0, c_cyc);
      prev_c = c_cyc;
    end
    expect_start(t1[0].ch, 3000, s_cyc, ok);
    check("gap_wrap", 32'(s_cyc - prev_c), 32'd64);
    check("sweep_done_pulse", 32'(sweep_done), 32'd1);
    check("all_valid_sweep1", 32'(all_valid), 32'd1);
    check("tmo_clean", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("sweep_done_width", 32'(sweep_done), 32'd0);
    check("sweep_count", 32'(sweep_cnt), 32'd1);

    // Watchdog: slot 2 never completes
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    conv(0, 12'h100, 20, 12'h100);
    conv(1, 12'h101, 20, 12'h101);
    expect_start(t1[2].ch, 3000, s_cyc, ok);
    wait_start(3000, ok);
    s2 = cyc;
    check("tmo_start_seen", 32'(ok), 32'd1);
    check("tmo_restart_cycles", 32'(s2 - s_cyc), 32'd2112);
    check("tmo_next_chnnl", 32'(chnnl), 32'(t1[3].ch));
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_b2_kept", 32'(POT_B2), 32'h800);
    if (ok) respond(3, 12'h103, 20, 12'h103, 1'b0, c_cyc);
    conv(4, 12'h104, 20, 12'h104);
    conv(5, 12'h105, 20, 12'h105);
    expect_start(t1[0].ch, 3000, s_cyc, ok);
    check("dirty_sweep_done", 32'(sweep_done), 32'd1);
    check("dirty_not_valid", 32'(all_valid), 32'd0);
    if (ok) respond(0, 12'h100, 20, 12'h100, 1'b0, c_cyc);
    for (int i = 1; i < 6; i++) conv(i, t1[i].rsp, 20, t1[i].rsp);
    expect_start(t1[0].ch, 3000, s_cyc, ok);
    check("clean_valid", 32'(all_valid), 32'd1);
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    // Reset in the middle of a conversion, then a stray completion while idle
    if (ok) respond(0, 12'h100, 20, 12'h100, 1'b0, c_cyc);
    expect_start(t1[1].ch, 3000, s_cyc, ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cnv_cmplt = 1'b1;
    res       = 12'hABC;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    check("stray_pot_upd", 32'(pot_upd), 32'd0);
    check("stray_pot_lp", 32'(POT_LP), 32'h800);
    wait_start(50, ok);
    check("idle_no_start", 32'(ok), 32'd0);

    // en dropped mid-conversion: finish, park, resume at next slot
    en = 1'b1;
    conv(0, 12'h200, 10, 12'h200);
    conv(1, 12'h201, 10, 12'h201);
    conv(2, 12'h202, 10, 12'h202);
    expect_start(t1[3].ch, 3000, s_cyc, ok);
    if (ok) respond(3, 12'h3AB, 30, 12'h3AB, 1'b1, c_cyc);
    wait_start(300, ok);
    check("parked_no_start", 32'(ok), 32'd0);
    en = 1'b1;
    expect_start(t1[4].ch, 10, s_cyc, ok);

    // Second reading of HP: smoothed when the filter option is built in
    if (ok) respond(4, 12'h400, 10, 12'h400, 1'b0, c_cyc);
    conv(5, 12'h405, 10, 12'h405);
    conv(0, 12'h200, 10, 12'h200);
    conv(1, 12'h201, 10, 12'h201);
    conv(2, 12'h202, 10, 12'h202);
    conv(3, 12'h3AB, 10, 12'h3AB);
`ifdef POT_SMOOTH_EN
    exp_hp = 12'h500;
`else
    exp_hp = 12'h800;
`endif
    conv(4, 12'h800, 10, exp_hp);

    check("strt_width", 32'(wide_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
